// File: rtl/hdc_sample_driver.sv
// hdc_sample_driver: streams quantized features into an HDC encoder core.
// Each accepted feature becomes one smp_en cycle carrying the level
// hypervector and the position hypervector for that feature slot.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid && ready are both 1. feat_ready depends only on the FSM state, never
// on feat_valid. Once res_valid rises, res_valid and res_class hold until
// res_ready is seen.
module hdc_sample_driver #(
    parameter int                 DIM      = 1024,
    parameter int                 SMP_SIZE = 16,
    parameter int                 SET_SIZE = 8,
    parameter int                 LVL_NUM  = 16,
    parameter logic [DIM-1:0]     POS_SEED = DIM'(1),
    parameter logic [DIM-1:0]     LVL_SEED = '0,
    parameter int                 WAIT_LAT = 3,
    parameter int                 CLS_NUM  = 2,
    localparam int                CLS_DW   = (CLS_NUM > 1) ? $clog2(CLS_NUM) : 1,
    localparam int                LV_W     = (LVL_NUM > 1) ? $clog2(LVL_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [LV_W-1:0]   feat_value,
    input  logic              feat_last,
    input  logic              mode,
    input  logic [CLS_DW-1:0] label_in,
    output logic [DIM-1:0]    im_value,
    output logic [DIM-1:0]    im_pos,
    output logic              smp_en,
    output logic              smp_clr,
    output logic              set_clr,
    output logic              state,
    output logic [CLS_DW-1:0] label,
    input  logic [CLS_DW-1:0] predict,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CLS_DW-1:0] res_class,
    output logic              train_done,
    output logic              err_last,
    output logic [2:0]        dbg_fsm
);

    localparam int FLIP = DIM / (LVL_NUM - 1);
    localparam int FI_W = (SMP_SIZE > 1) ? $clog2(SMP_SIZE) : 1;
    localparam int SI_W = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;
    localparam int WC_W = (WAIT_LAT > 1) ? $clog2(WAIT_LAT) : 1;

    localparam logic [FI_W-1:0] FI_LAST = FI_W'(SMP_SIZE - 1);
    localparam logic [SI_W-1:0] SI_LAST = SI_W'(SET_SIZE - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } fsm_t;

    fsm_t            fsm_q;
    fsm_t            fsm_nxt;
    logic [FI_W-1:0] feat_idx;
    logic [SI_W-1:0] set_idx;
    logic [WC_W-1:0] wait_cnt;
    logic            feat_hs;
    logic            feat_at_end;
    logic            wait_done;

    int              lvl_q;
    int              flip_bits;
    int              rot_amt;
    logic [DIM-1:0]  lvl_hv;
    logic [2*DIM-1:0] pos_dbl;
    logic [DIM-1:0]  pos_hv;

    assign dbg_fsm     = fsm_q;
    assign feat_hs     = feat_valid && feat_ready;
    assign feat_at_end = (feat_idx == FI_LAST);
    assign wait_done   = (fsm_q == S_WAIT) && (wait_cnt == WC_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_nxt;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        fsm_nxt    = fsm_q;
        feat_ready = 1'b0;
        smp_clr    = 1'b0;
        set_clr    = 1'b0;
        res_valid  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (feat_valid) fsm_nxt = S_CLR;
            end
            S_CLR: begin
                // mode is latched on this same edge, so the live value is the latched one.
                smp_clr = 1'b1;
                set_clr = (mode == 1'b0) && (set_idx == '0);
                fsm_nxt = S_STREAM;
            end
            S_STREAM: begin
                feat_ready = 1'b1;
                if (feat_valid && feat_at_end) fsm_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WC_LAST) fsm_nxt = state ? S_RESULT : S_IDLE;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) fsm_nxt = S_IDLE;
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // Level hypervector: flip the low q*FLIP bits of the seed, q clamped to the top level.
    always_comb begin
        lvl_q     = (int'(feat_value) >= LVL_NUM) ? (LVL_NUM - 1) : int'(feat_value);
        flip_bits = lvl_q * FLIP;
        lvl_hv    = LVL_SEED;
        for (int i = 0; i < DIM; i++) begin
            if (i < flip_bits) lvl_hv[i] = ~LVL_SEED[i];
        end
    end

    // Position hypervector: seed rotated left by the feature index.
    always_comb begin
        rot_amt = int'(feat_idx) % DIM;
        pos_dbl = {POS_SEED, POS_SEED} << rot_amt;
        pos_hv  = pos_dbl[2*DIM-1:DIM];
    end

    // Datapath: sample context, feature issue, wait timer, set bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= 1'b0;
            label      <= '0;
            smp_en     <= 1'b0;
            im_value   <= '0;
            im_pos     <= '0;
            feat_idx   <= '0;
            set_idx    <= '0;
            wait_cnt   <= '0;
            res_class  <= '0;
            train_done <= 1'b0;
            err_last   <= 1'b0;
        end else begin
            smp_en     <= 1'b0;
            train_done <= 1'b0;

            if (fsm_q == S_CLR) begin
                state <= mode;
                label <= label_in;
            end

            if (feat_hs) begin
                smp_en   <= 1'b1;
                im_value <= lvl_hv;
                im_pos   <= pos_hv;
                feat_idx <= feat_at_end ? '0 : feat_idx + 1'b1;
                // The count decides sample length; a misplaced feat_last is only flagged.
                if (feat_last != feat_at_end) err_last <= 1'b1;
            end

            if (fsm_q == S_WAIT) begin
                wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
            end

            if (wait_done) begin
                if (state) begin
                    res_class <= predict;
                end else if (set_idx == SI_LAST) begin
                    set_idx    <= '0;
                    train_done <= 1'b1;
                end else begin
                    set_idx <= set_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/hdc_sample_driver.md
HDC_SAMPLE_DRIVER -- requirements
Module: hdc_sample_driver

Interface
REQ-001 SHALL have parameter DIM, default 1024, hypervector width.
REQ-002 SHALL have parameter SMP_SIZE, default 16, features per sample.
REQ-003 SHALL have parameter SET_SIZE, default 8, samples per training set.
REQ-004 SHALL have parameter LVL_NUM, default 16, quantization levels; FLIP = DIM/(LVL_NUM-1), integer floor.
REQ-005 SHALL have parameters POS_SEED and LVL_SEED, default DIM'(1) and '0, base hypervectors.
REQ-006 SHALL have parameter WAIT_LAT, default 3, cycles from last smp_en to predict sampling.
REQ-007 SHALL have parameter CLS_NUM, default 2; CLS_DW = $clog2(CLS_NUM).
REQ-008 One clock; reset is asynchronous and active-low: clk input 1, rst_n input 1.
REQ-009 feat_valid input 1; feature offered.
REQ-010 feat_ready output 1; feature accepted when feat_valid && feat_ready.
REQ-011 feat_value input $clog2(LVL_NUM); quantized level.
REQ-012 feat_last input 1; marks last feature of a sample.
REQ-013 mode input 1; 0 = TRAIN, 1 = PREDICT.
REQ-014 label_in input CLS_DW; class for training.
REQ-015 Core outputs: im_value DIM, im_pos DIM, smp_en 1, smp_clr 1, set_clr 1, state 1, label CLS_DW.
REQ-016 predict input CLS_DW; core classification.
REQ-017 res_valid output 1, res_ready input 1, res_class output CLS_DW; result handshake.
REQ-018 train_done output 1; one-cycle pulse per completed set.
REQ-019 err_last output 1; sticky framing error.

Function
REQ-020 SHALL implement FSM IDLE, CLR, STREAM, WAIT, RESULT.
REQ-021 IDLE -> CLR when feat_valid=1; feat_ready=0 in IDLE.
REQ-022 CLR, 1 cycle: latch mode->state, label_in->label; assert smp_clr; assert set_clr iff latched mode=TRAIN and set_idx=0; -> STREAM.
REQ-023 mode/label_in changes outside CLR SHALL NOT affect state/label.
REQ-024 STREAM: feat_ready=1; on each handshake, next cycle smp_en=1, im_value=LVL(feat_value), im_pos=POS(feat_idx); smp_en=0 otherwise.
REQ-025 POS(i) = POS_SEED rotated left by i bits.
REQ-026 LVL(q) = LVL_SEED XOR mask, mask having low q*FLIP bits set; q >= LVL_NUM clamps to LVL_NUM-1.
REQ-027 feat_idx counts handshakes 0..SMP_SIZE-1; after the SMP_SIZE-th handshake -> WAIT, feat_idx=0.
REQ-028 feat_last=1 on a handshake with feat_idx != SMP_SIZE-1, or =0 at feat_idx = SMP_SIZE-1, SHALL set err_last; sample length is governed by count only.
REQ-029 WAIT counts WAIT_LAT cycles after the final smp_en cycle, then: PREDICT -> RESULT, capturing predict into res_class; TRAIN -> IDLE, incrementing set_idx.
REQ-030 set_idx wrap SET_SIZE-1 -> 0 SHALL pulse train_done for 1 cycle.
REQ-031 RESULT: res_valid=1, res_class stable until res_ready=1; then -> IDLE the cycle after handshake.
REQ-032 Switching mode between samples SHALL NOT clear set_idx; a PREDICT sample mid-set leaves set_idx unchanged.

Reset
REQ-033 On rst_n=0 (any state, mid-sample included): FSM=IDLE; feat_idx, set_idx, WAIT counter = 0.
REQ-034 Reset values: all outputs 0, including feat_ready, smp_en, smp_clr, set_clr, res_valid, train_done, err_last, im_value, im_pos, state, label, res_class.
REQ-035 First sample after reset in TRAIN SHALL assert set_clr.

Verification
REQ-036 DIM=16, LVL_NUM=5, POS_SEED=16'h8001, LVL_SEED=0: feature 1, level 2 -> im_pos=16'h0003, im_value=16'h00FF, smp_en 1 cycle.
REQ-037 SMP_SIZE=4, PREDICT, predict=1: 4 back-to-back features -> smp_clr once, 4 smp_en, res_valid exactly WAIT_LAT cycles after last smp_en, res_class=1.
REQ-038 SET_SIZE=2, TRAIN: 2 samples -> set_clr only on first CLR; train_done pulses once after second WAIT; third sample asserts set_clr again.
REQ-039 feat_last on feature 2 of 4 -> err_last=1 and stays 1; sample still consumes 4 features.
REQ-040 res_ready=0 for 5 cycles -> res_valid/res_class held; feat_ready=0 until handshake.
REQ-041 rst_n=0 after 2 of 4 features -> all outputs 0; next sample restarts at feat_idx 0 with set_clr asserted.
